cwt_scale_mul: RTL and testbench

CWT_SCALE_MUL -- requirements
Module: cwt_scale_mul

---
 rtl/cwt_scale_mul.sv | 179 +++++++++++++++++
 tb/tb_cwt_scale_mul.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwt_scale_mul.sv
// rtl/cwt_scale_mul.sv - buffers one FFT frame and multiplies it by J daughter-wavelet coefficient sets
module cwt_scale_mul #(
    parameter int N    = 1024,
    parameter int J    = 4,
    parameter int DW   = 32,
    parameter int CW   = 32,
    parameter int FRAC = 15
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      in_valid_i,
    input  logic signed [DW-1:0]      x_re_i,
    input  logic signed [DW-1:0]      x_im_i,
    input  logic [$clog2(J):0]        num_scales_i,
    output logic [$clog2(N*J)-1:0]    daughter_addr_o,
    input  logic signed [CW-1:0]      daughter_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic signed [DW-1:0]      X_re_o,
    output logic signed [DW-1:0]      X_im_o,
    output logic [$clog2(J)-1:0]      scale_o,
    output logic                      last_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      overrun_o
);
    localparam int NW = $clog2(N);
    localparam int JW = $clog2(J);
    localparam int PW = DW + CW;
    localparam logic signed [PW-1:0] RND  = PW'(1) << (FRAC - 1);
    localparam logic signed [PW-1:0] MAXV = {{(CW + 1){1'b0}}, {(DW - 1){1'b1}}};
    localparam logic signed [PW-1:0] MINV = {{(CW + 1){1'b1}}, {(DW - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, LOAD, MUL} state_t;
    state_t state, state_nx;

    logic signed [DW-1:0] buf_re [N];
    logic signed [DW-1:0] buf_im [N];

    logic [NW-1:0]        wr_n, rd_n;
    logic [JW-1:0]        rd_j, s_last, j1;
    logic                 issuing, v1, last1, fin1, out_fin;
    logic signed [DW-1:0] x1_re, x1_im;
    logic signed [CW-1:0] c_hold, c_use;
    logic                 hold;
    logic                 stall, store, issue, rd_final, load_done, accept_last;

    function automatic logic [JW-1:0] clamp_scales(input logic [JW:0] ns);
        if (ns == '0)
            return '0;
        else if (int'(ns) > J)
            return JW'(J - 1);
        else
            return JW'(ns - 1'b1);
    endfunction

    function automatic logic signed [DW-1:0] mul_rnd(input logic signed [DW-1:0] x,
                                                     input logic signed [CW-1:0] c);
        logic signed [PW-1:0] p;
        p = x * c;
        p = (p + RND) >>> FRAC;
        if (p > MAXV)
            return MAXV[DW-1:0];
        else if (p < MINV)
            return MINV[DW-1:0];
        else
            return p[DW-1:0];
    endfunction

    assign stall       = out_valid_o & ~out_ready_i;
    assign store       = in_valid_i && (state != MUL);
    assign load_done   = (state == LOAD) && in_valid_i && (wr_n == NW'(N - 1));
    assign issue       = (state == MUL) && issuing && !stall;
    assign rd_final    = (rd_n == NW'(N - 1)) && (rd_j == s_last);
    assign accept_last = out_valid_o && out_ready_i && out_fin;
    // N is a power of two, so j*N+n is a plain concatenation with no carry into j
    assign daughter_addr_o = {rd_j, rd_n};
    // ROM data only lines up with its address for one cycle; keep a copy while stalled
    assign c_use = hold ? c_hold : daughter_i;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (in_valid_i) state_nx = LOAD;
            LOAD:    if (load_done) state_nx = MUL;
            MUL:     if (accept_last) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state == LOAD) || (state == MUL);
    end

    always_ff @(posedge clk) begin
        if (store) begin
            buf_re[wr_n] <= x_re_i;
            buf_im[wr_n] <= x_im_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_n      <= '0;
            rd_n      <= '0;
            rd_j      <= '0;
            s_last    <= '0;
            issuing   <= 1'b0;
            overrun_o <= 1'b0;
            done_o    <= 1'b0;
        end else begin
            done_o <= accept_last;
            if (store)
                wr_n <= wr_n + 1'b1;
            if (state == IDLE && in_valid_i) begin
                s_last    <= clamp_scales(num_scales_i);
                overrun_o <= 1'b0;
            end
            if (state == MUL && in_valid_i)
                overrun_o <= 1'b1;
            if (load_done) begin
                issuing <= 1'b1;
                rd_n    <= '0;
                rd_j    <= '0;
            end else if (issue) begin
                rd_n <= rd_n + 1'b1;
                if (rd_n == NW'(N - 1)) begin
                    rd_j <= rd_final ? '0 : rd_j + 1'b1;
                    if (rd_final)
                        issuing <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1          <= 1'b0;
            j1          <= '0;
            last1       <= 1'b0;
            fin1        <= 1'b0;
            x1_re       <= '0;
            x1_im       <= '0;
            hold        <= 1'b0;
            c_hold      <= '0;
            out_valid_o <= 1'b0;
            X_re_o      <= '0;
            X_im_o      <= '0;
            scale_o     <= '0;
            last_o      <= 1'b0;
            out_fin     <= 1'b0;
        end else if (stall) begin
            hold <= 1'b1;
            if (!hold)
                c_hold <= daughter_i;
        end else begin
            hold        <= 1'b0;
            v1          <= issue;
            j1          <= rd_j;
            last1       <= (rd_n == NW'(N - 1));
            fin1        <= rd_final;
            x1_re       <= buf_re[rd_n];
            x1_im       <= buf_im[rd_n];
            out_valid_o <= v1;
            X_re_o      <= mul_rnd(x1_re, c_use);
            X_im_o      <= mul_rnd(x1_im, c_use);
            scale_o     <= j1;
            last_o      <= last1;
            out_fin     <= v1 & fin1;
        end
    end
endmodule

// File: tb/tb_cwt_scale_mul.sv
// tb/tb_cwt_scale_mul.sv - randomized self-checking bench for cwt_scale_mul
module tb_cwt_scale_mul;
    localparam int N = 8, J = 2, DW = 16, CW = 16, FRAC = 15;
    localparam int JW = 1, AW = 4;

    typedef struct packed {int re; int im; int sc; int lst;} res_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic in_valid_i = 1'b0;
    logic signed [DW-1:0] x_re_i = '0, x_im_i = '0;
    logic [JW:0] num_scales_i = '0;
    logic [AW-1:0] daughter_addr_o;
    logic signed [CW-1:0] daughter_i = '0;
    logic out_valid_o, out_ready_i = 1'b0;
    logic signed [DW-1:0] X_re_o, X_im_o;
    logic [JW-1:0] scale_o;
    logic last_o, busy_o, done_o, overrun_o;

    int vec = 0, errs = 0, cyc = 0;
    int fx_re [N];
    int fx_im [N];
    int rom [N*J];
    res_t got_q [$];
    int done_cnt, done_cyc, acc_cyc, first_cyc, stall_viol, last_in_cyc;
    logic prev_stall = 1'b0;
    logic [AW-1:0] p_addr;
    logic signed [DW-1:0] p_re, p_im;

    cwt_scale_mul #(.N(N), .J(J), .DW(DW), .CW(CW), .FRAC(FRAC)) dut (
        .clk(clk), .rstn(rstn), .in_valid_i(in_valid_i), .x_re_i(x_re_i), .x_im_i(x_im_i),
        .num_scales_i(num_scales_i), .daughter_addr_o(daughter_addr_o), .daughter_i(daughter_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .X_re_o(X_re_o), .X_im_o(X_im_o),
        .scale_o(scale_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o), .overrun_o(overrun_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) daughter_i <= CW'(rom[daughter_addr_o]);

    always @(negedge clk) begin
        if (!rstn) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && (daughter_addr_o !== p_addr || X_re_o !== p_re || X_im_o !== p_im || out_valid_o !== 1'b1))
                stall_viol++;
            if (out_valid_o && first_cyc < 0) first_cyc = cyc;
            if (out_valid_o && out_ready_i) begin
                got_q.push_back('{int'(X_re_o), int'(X_im_o), int'(scale_o), int'(last_o)});
                acc_cyc = cyc;
            end
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_stall = out_valid_o && !out_ready_i;
            p_addr = daughter_addr_o;
            p_re = X_re_o;
            p_im = X_im_o;
        end
    end

    function automatic int rand16();
        logic signed [15:0] r;
        r = 16'($urandom);
        return int'(r);
    endfunction

    function automatic int ref_mul(int x, int c);
        longint p;
        p = (longint'(x) * longint'(c) + (longint'(1) << (FRAC - 1))) >>> FRAC;
        if (p > 32767) p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic feed_frame(input int ns);
        got_q.delete();
        done_cnt = 0; done_cyc = -1; acc_cyc = -1; first_cyc = -1; stall_viol = 0;
        for (int n = 0; n < N; n++) begin
            while ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
                in_valid_i = 1'b0;
            end
            @(posedge clk); #1;
            in_valid_i = 1'b1;
            x_re_i = DW'(fx_re[n]);
            x_im_i = DW'(fx_im[n]);
            num_scales_i = (JW + 1)'(ns);
            last_in_cyc = cyc;
            if (n == 1) begin
                vec++;
                if (overrun_o !== 1'b0) begin
                    errs++;
                    $display("FAIL overrun_clear_on_start got %0b exp 0", overrun_o);
                end
            end
        end
    endtask

    task automatic run_frame(input int ns, input int rmode, input int ovr, input string tag);
        res_t exp_q [$];
        int s, t;
        s = (ns == 0) ? 1 : (ns > J ? J : ns);
        for (int j = 0; j < s; j++)
            for (int n = 0; n < N; n++)
                exp_q.push_back('{ref_mul(fx_re[n], rom[j*N+n]), ref_mul(fx_im[n], rom[j*N+n]), j, int'(n == N-1)});
        out_ready_i = 1'b1;
        feed_frame(ns);
        t = 0;
        while (done_cnt == 0 && t < 400) begin
            @(posedge clk); #1;
            t++;
            in_valid_i = (ovr != 0 && t >= 2 && t <= 5);
            x_re_i = DW'(rand16());
            out_ready_i = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(t % 2) : 1'($urandom_range(0, 1));
        end
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        vec++;
        if (got_q.size() != exp_q.size()) begin
            errs++;
            $display("FAIL %s result_count got %0d exp %0d", tag, got_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            vec++;
            if (got_q[i] !== exp_q[i]) begin
                errs++;
                $display("FAIL %s result[%0d] got re=%0d im=%0d sc=%0d last=%0d exp re=%0d im=%0d sc=%0d last=%0d",
                         tag, i, got_q[i].re, got_q[i].im, got_q[i].sc, got_q[i].lst,
                         exp_q[i].re, exp_q[i].im, exp_q[i].sc, exp_q[i].lst);
            end
        end
        vec++;
        if (done_cnt != 1) begin
            errs++;
            $display("FAIL %s done_count got %0d exp 1", tag, done_cnt);
        end
        vec++;
        if (done_cyc != acc_cyc + 1) begin
            errs++;
            $display("FAIL %s done_timing got cycle %0d exp %0d", tag, done_cyc, acc_cyc + 1);
        end
        vec++;
        if (first_cyc != last_in_cyc + 3) begin
            errs++;
            $display("FAIL %s first_valid_latency got cycle %0d exp %0d", tag, first_cyc, last_in_cyc + 3);
        end
        vec++;
        if (stall_viol != 0) begin
            errs++;
            $display("FAIL %s stall_hold got %0d violations exp 0", tag, stall_viol);
        end
        vec++;
        if (overrun_o !== 1'(ovr != 0) || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL %s end_flags got overrun=%0b busy=%0b exp overrun=%0b busy=0", tag, overrun_o, busy_o, ovr != 0);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        vec++;
        if ({out_valid_o, X_re_o, X_im_o, scale_o, last_o, busy_o, done_o, overrun_o, daughter_addr_o} !== '0) begin
            errs++;
            $display("FAIL reset_state got valid=%0b re=%0d im=%0d sc=%0d busy=%0b done=%0b ovr=%0b addr=%0d exp all 0",
                     out_valid_o, X_re_o, X_im_o, scale_o, busy_o, done_o, overrun_o, daughter_addr_o);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_ramp();
        for (int n = 0; n < N; n++) begin fx_re[n] = n; fx_im[n] = -n; end
        for (int a = 0; a < N*J; a++) rom[a] = 16384;
        run_frame(2, 0, 0, "ramp");
        vec++;
        if (got_q.size() > 3 && (got_q[3].re !== 2 || got_q[3].im !== -1)) begin
            errs++;
            $display("FAIL ramp_n3 got re=%0d im=%0d exp re=2 im=-1", got_q[3].re, got_q[3].im);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < N; n++) begin fx_re[n] = 32767; fx_im[n] = -32768; end
        for (int a = 0; a < N*J; a++) rom[a] = -32768;
        run_frame(2, 0, 0, "sat");
        vec++;
        if (got_q.size() == 0 || got_q[0].re !== -32767 || got_q[0].im !== 32767) begin
            errs++;
            $display("FAIL sat_value got re=%0d im=%0d exp re=-32767 im=32767",
                     got_q.size() ? got_q[0].re : 0, got_q.size() ? got_q[0].im : 0);
        end
    endtask

    task automatic randomize_frame();
        for (int n = 0; n < N; n++) begin fx_re[n] = rand16(); fx_im[n] = rand16(); end
        for (int a = 0; a < N*J; a++) rom[a] = rand16();
        fx_re[0] = 32767; fx_im[1] = -32768; rom[0] = -32768;
    endtask

    task automatic test_stall_toggle();
        randomize_frame();
        run_frame(2, 1, 0, "toggle");
    endtask

    task automatic test_scale_clamp();
        randomize_frame();
        run_frame(0, 0, 0, "scales0");
        run_frame(3, 0, 0, "scales3");
        run_frame(1, 2, 0, "scales1");
    endtask

    task automatic test_overrun();
        randomize_frame();
        run_frame(2, 0, 1, "overrun");
        randomize_frame();
        run_frame(2, 0, 0, "after_overrun");
    endtask

    task automatic test_reset_mid();
        int t;
        randomize_frame();
        out_ready_i = 1'b1;
        feed_frame(2);
        t = 0;
        while (got_q.size() < 5 && t < 200) begin
            @(posedge clk); #1;
            t++;
            in_valid_i = 1'b0;
        end
        rstn = 1'b0;
        #1;
        vec++;
        if ({out_valid_o, X_re_o, X_im_o, scale_o, last_o, busy_o, done_o, overrun_o, daughter_addr_o} !== '0) begin
            errs++;
            $display("FAIL mid_reset_state got valid=%0b re=%0d im=%0d busy=%0b done=%0b addr=%0d exp all 0",
                     out_valid_o, X_re_o, X_im_o, busy_o, done_o, daughter_addr_o);
        end
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        vec++;
        if (done_cnt != 0) begin
            errs++;
            $display("FAIL mid_reset_no_done got %0d exp 0", done_cnt);
        end
        randomize_frame();
        run_frame(2, 0, 0, "post_reset");
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            randomize_frame();
            run_frame($urandom_range(0, 3), 2, $urandom_range(0, 1), "random");
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_saturation();
        test_stall_toggle();
        test_scale_clamp();
        test_overrun();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
